multdiv_unit: RTL and testbench

// - Multi-cycle signed multiply/divide unit at the execute stage. It handles the R-type ops that the ALU control path

---
 rtl/multdiv_unit.sv | 132 +++++++++++++
 tb/tb_multdiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed mul/div, one bit per cycle; result_rdy pulses WIDTH+2 cycles after accept (div by zero: 1).
// No handshake: stall holds the pipe while busy. Define MULTDIV_OVF_EN to flag multiply overflow via exception.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [31:0]      DXIR,
   input  logic             issue,
   input  logic             flush,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             is_md,
   output logic             stall,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       result_rd,
   output logic             result_rdy,
   output logic             exception
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_b;
   logic               neg;
   logic               is_div;

   logic [4:0]         opcode;
   logic [4:0]         aluop;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   fix_lo;
   logic               unused_ir;

   assign opcode    = DXIR[31:27];
   assign aluop     = DXIR[6:2];
   assign unused_ir = ^{DXIR[21:7], DXIR[1:0]};

   assign is_md = (opcode == 5'd0) && ((aluop == 5'd6) || (aluop == 5'd7));
   assign stall = ((state == IDLE) && is_md && issue) || (state == RUN) || (state == FIX);

   assign mag_a_in = operandA[WIDTH-1] ? -operandA : operandA;
   assign mag_b_in = operandB[WIDTH-1] ? -operandB : operandB;

   // mul: acc = {partial high, remaining multiplier}; the add result shifts in from the top
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

   // div: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, mag_b};

   assign fix_lo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

`ifdef MULTDIV_OVF_EN
   logic [2*WIDTH-1:0] prod_signed;
   logic               mul_ovf;
   assign prod_signed = neg ? -acc : acc;
   assign mul_ovf     = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         counter    <= '0;
         acc        <= '0;
         mag_b      <= '0;
         neg        <= 1'b0;
         is_div     <= 1'b0;
         result     <= '0;
         result_rd  <= '0;
         result_rdy <= 1'b0;
         exception  <= 1'b0;
      end else begin
         result_rdy <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (is_md && issue) begin
                     is_div    <= aluop[0];
                     neg       <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                     result_rd <= DXIR[26:22];
                     exception <= 1'b0;
                     counter   <= '0;
                     mag_b     <= mag_b_in;
                     acc       <= {{WIDTH{1'b0}}, mag_a_in};
                     if (aluop[0] && (operandB == '0)) begin
                        result     <= '0;
                        exception  <= 1'b1;
                        result_rdy <= 1'b1;
                        state      <= DONE;
                     end else begin
                        state <= RUN;
                     end
                  end
               end
               RUN: begin
                  if (is_div) begin
                     if (div_diff[WIDTH])
                        acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                     else
                        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= {mul_sum, acc[WIDTH-1:1]};
                  end
                  counter <= counter + CNT_W'(1);
                  if (counter == CNT_W'(WIDTH - 1))
                     state <= FIX;
               end
               FIX: begin
                  result     <= fix_lo;
`ifdef MULTDIV_OVF_EN
                  exception  <= !is_div && mul_ovf;
`endif
                  result_rdy <= 1'b1;
                  state      <= DONE;
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed corner cases plus randomized mul/div against a signed-arithmetic reference.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        issue = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] DXIR = '0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        is_md, stall, result_rdy, exception;
   logic [31:0] result;
   logic [4:0]  result_rd;

   int vectors = 0;
   int miscompares = 0;

   multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .reset_n(reset_n), .DXIR(DXIR), .issue(issue), .flush(flush),
      .operandA(operandA), .operandB(operandB), .is_md(is_md), .stall(stall),
      .result(result), .result_rd(result_rd), .result_rdy(result_rdy), .exception(exception)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] aluop);
      mk_ir = {opc, rd, 15'($urandom), aluop, 2'($urandom)};
   endfunction

   // Reference: exact signed arithmetic in 64 bits, truncated to the low word
   function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint sa, sb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (div) begin
         if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
         end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
         end
      end else begin
         p = sa * sb;
         r = p[31:0];
`ifdef MULTDIV_OVF_EN
         e = (p != {{32{r[31]}}, r});
`else
         e = 1'b0;
`endif
      end
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] specials [6];
      specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
      case ($urandom_range(0, 3))
         0: pick = specials[$urandom_range(0, 5)];
         1: pick = 32'($signed(8'($urandom)));
         default: pick = $urandom;
      endcase
   endfunction

   task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b, input bit hold);
      logic [31:0] exp_r;
      logic        exp_e;
      logic [4:0]  rd;
      int          lat, stall_cyc, exp_lat;
      bit          seen;
      model(div, a, b, exp_r, exp_e);
      exp_lat = (div && b == 32'd0) ? 1 : 34;
      rd = 5'($urandom);
      @(negedge clock);
      DXIR = mk_ir(5'd0, rd, div ? 5'd7 : 5'd6);
      operandA = a;
      operandB = b;
      issue = 1'b1;
      #1;
      check("is_md", is_md, 1);
      check("stall_at_accept", stall, 1);
      stall_cyc = 1;
      lat = 0;
      seen = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(negedge clock);
         if (!hold) issue = 1'b0;
         operandA = $urandom;
         operandB = $urandom;
         #1;
         if (result_rdy) begin
            seen = 1;
            lat = c;
         end else if (stall) begin
            stall_cyc++;
         end
      end
      check("latency", lat, exp_lat);
      check("stall_cycles", stall_cyc, exp_lat);
      check("result", result, exp_r);
      check("exception", exception, exp_e);
      check("result_rd", result_rd, rd);
      check("stall_in_done", stall, 0);
      @(negedge clock);
      issue = 1'b0;
      #1;
      check("pulse_width", result_rdy, 0);
      check("no_reaccept", stall, 0);
      check("result_hold", result, exp_r);
   endtask

   task automatic start_op(input bit div);
      @(negedge clock);
      DXIR = mk_ir(5'd0, 5'($urandom), div ? 5'd7 : 5'd6);
      operandA = $urandom;
      operandB = $urandom | 32'd1;
      issue = 1'b1;
      @(negedge clock);
      issue = 1'b0;
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int n = 0;
      repeat (cycles) begin
         @(negedge clock);
         #1;
         if (result_rdy) n++;
      end
      check(tag, n, 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      #1;
      check("rst_result", result, 0);
      check("rst_rd", result_rd, 0);
      check("rst_rdy", result_rdy, 0);
      check("rst_exc", exception, 0);
      check("rst_stall", stall, 0);
      reset_n = 1'b1;

      run_op(0, 32'd7, 32'd6, 0);
      run_op(0, -32'sd7, 32'd6, 1);
      run_op(1, -32'sd100, 32'd7, 0);
      run_op(1, 32'd100, -32'sd7, 1);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(1, 32'd5, 32'd0, 1);
      run_op(0, 32'h0001_0000, 32'h0001_0000, 0);
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);

      // reset in the middle of a multiply
      start_op(0);
      repeat (9) @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_result", result, 0);
      check("midrst_rd", result_rd, 0);
      check("midrst_rdy", result_rdy, 0);
      check("midrst_exc", exception, 0);
      check("midrst_stall", stall, 0);
      @(negedge clock);
      reset_n = 1'b1;
      expect_quiet("midrst_no_pulse", 40);
      run_op(0, 32'd3, 32'd3, 0);

      // flush in the middle of a divide
      start_op(1);
      repeat (4) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      #1;
      check("flush_stall", stall, 0);
      expect_quiet("flush_no_pulse", 40);

      // flush together with issue in IDLE blocks the accept
      @(negedge clock);
      DXIR = mk_ir(5'd0, 5'd3, 5'd6);
      issue = 1'b1;
      flush = 1'b1;
      @(negedge clock);
      issue = 1'b0;
      flush = 1'b0;
      #1;
      check("flush_idle_stall", stall, 0);
      expect_quiet("flush_idle_no_pulse", 40);

      // non-md instructions
      @(negedge clock);
      DXIR = mk_ir(5'd0, 5'd9, 5'd0);
      issue = 1'b1;
      #1;
      check("alu0_is_md", is_md, 0);
      check("alu0_stall", stall, 0);
      @(negedge clock);
      DXIR = mk_ir(5'd4, 5'd9, 5'd6);
      #1;
      check("opc4_is_md", is_md, 0);
      check("opc4_stall", stall, 0);
      @(negedge clock);
      issue = 1'b0;
      #1;
      check("nonmd_rdy", result_rdy, 0);
      check("nonmd_idle", stall, 0);

      for (int i = 0; i < 24; i++)
         run_op(1'($urandom), pick(), pick(), 1'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
